// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared states and constants for the 6502 bus arbiter
package bus_arbiter_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 3'd0;
  localparam arb_state_t ST_HALT   = 3'd1;
  localparam arb_state_t ST_FLOAT  = 3'd2;
  localparam arb_state_t ST_XFER   = 3'd3;
  localparam arb_state_t ST_ACK    = 3'd4;
  localparam arb_state_t ST_RETURN = 3'd5;

  localparam logic BUS_RW_READ  = 1'b1;
  localparam logic BUS_RW_WRITE = 1'b0;

  localparam logic [15:0] BUS_ADDR_RST  = 16'h0000;
  localparam logic [7:0]  BUS_WDATA_RST = 8'h00;
  localparam logic        BUS_RW_RST    = BUS_RW_READ;

  // True when the captured rw value selects a bus read.
  function automatic logic is_read(input logic rw);
    return rw != BUS_RW_WRITE;
  endfunction

endpackage

// File: rtl/arb_down_counter.sv
// rtl/arb_down_counter.sv - loadable down counter that saturates at zero
module arb_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  // Load has priority; decrement stops at zero so the counter never wraps.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - CPU / FPGA-master 6502 bus arbiter (optional BUS_ARBITER_WAIT_EN wait states)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX   = 16,
  parameter int FAIR_GAP    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_b,
  output logic        cpu_rdy,
  output logic        cpu_be,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_rw,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [7:0]  dma_rdata,
  output logic        bus_oe,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw,
  input  logic [7:0]  bus_rdata
);

  localparam int BW    = $clog2(BURST_MAX + 1);
  localparam int GAP_W = (FAIR_GAP > 0) ? $clog2(FAIR_GAP + 1) : 1;

  arb_state_t     state_q;
  arb_state_t     state_d;
  logic [BW-1:0]  burst_q;
  logic [GAP_W-1:0] gap_count;
  logic           gap_ready;
  logic           xfer_last;
  logic           capture;

  // The last guaranteed CPU cycle may already decide the re-grant, so the
  // CPU sees exactly FAIR_GAP IDLE cycles before the next HALT.
  assign gap_ready = (gap_count <= GAP_W'(1));

  arb_down_counter #(.WIDTH(GAP_W)) u_gap_counter (
    .clock      (clock),
    .reset_b    (reset_b),
    .load       (state_q == ST_RETURN),
    .load_value (GAP_W'(FAIR_GAP)),
    .dec        (state_q == ST_IDLE),
    .count      (gap_count)
  );

`ifdef BUS_ARBITER_WAIT_EN
  localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [WAIT_W-1:0] wait_count;

  // Reloaded with every new access; XFER ends once it has run down to zero.
  arb_down_counter #(.WIDTH(WAIT_W)) u_wait_counter (
    .clock      (clock),
    .reset_b    (reset_b),
    .load       (capture),
    .load_value (WAIT_W'(WAIT_STATES)),
    .dec        (state_q == ST_XFER),
    .count      (wait_count)
  );

  assign xfer_last = (wait_count == '0);
`else
  // Without wait states every XFER is a single cycle for any legal setting.
  assign xfer_last = (WAIT_STATES >= 0);
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dma_req && gap_ready) state_d = ST_HALT;
      ST_HALT:   state_d = dma_req ? ST_FLOAT : ST_RETURN;
      ST_FLOAT:  state_d = dma_req ? ST_XFER : ST_RETURN;
      ST_XFER:   if (xfer_last) state_d = ST_ACK;
      ST_ACK:    state_d = (dma_req && (burst_q < BW'(BURST_MAX))) ? ST_XFER : ST_RETURN;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign capture = (state_d == ST_XFER) && ((state_q == ST_FLOAT) || (state_q == ST_ACK));

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_IDLE;
      cpu_rdy  <= 1'b1;
      cpu_be   <= 1'b1;
      bus_oe   <= 1'b0;
      dma_gnt  <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_rdy  <= (state_d == ST_IDLE);
      cpu_be   <= !(state_d inside {ST_FLOAT, ST_XFER, ST_ACK});
      bus_oe   <= (state_d inside {ST_XFER, ST_ACK});
      dma_gnt  <= (state_d inside {ST_XFER, ST_ACK});
      dma_done <= (state_d == ST_ACK);
    end
  end

  // Count completed accesses of the current grant; the step lands as ACK is
  // entered so ACK decides on the count including its own access.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      burst_q <= '0;
    end else if (capture && (state_q == ST_FLOAT)) begin
      burst_q <= '0;
    end else if ((state_q == ST_XFER) && xfer_last && (burst_q != BW'(BURST_MAX))) begin
      burst_q <= burst_q + BW'(1);
    end
  end

  // Latch the master's access into the bus drivers at the start of each XFER.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bus_addr  <= BUS_ADDR_RST;
      bus_wdata <= BUS_WDATA_RST;
      bus_rw    <= BUS_RW_RST;
    end else if (capture) begin
      bus_addr  <= dma_addr;
      bus_wdata <= dma_wdata;
      bus_rw    <= dma_rw;
    end
  end

  // Read data is sampled on the final XFER edge and held until the next read.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      dma_rdata <= 8'h00;
    end else if ((state_q == ST_XFER) && xfer_last && is_read(bus_rw)) begin
      dma_rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  localparam int BURST_MAX   = 16;
  localparam int FAIR_GAP    = 4;
  localparam int WAIT_STATES = 2;
`ifdef BUS_ARBITER_WAIT_EN
  localparam int XW = 1 + WAIT_STATES;
`else
  localparam int XW = 1;
`endif

  localparam logic [4:0] C_IDLE   = 5'b11000;
  localparam logic [4:0] C_HALT   = 5'b01000;
  localparam logic [4:0] C_FLOAT  = 5'b00000;
  localparam logic [4:0] C_XFER   = 5'b00110;
  localparam logic [4:0] C_ACK    = 5'b00111;
  localparam logic [4:0] C_RETURN = 5'b01000;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset_b;
  logic        cpu_rdy, cpu_be;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        dma_gnt, dma_done;
  logic [7:0]  dma_rdata;
  logic        bus_oe;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;

  acc_t pend[$];
  acc_t sb[$];
  int   done_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   drv_en = 1'b0;
  logic [7:0] last_rdata = 8'h00;

  bus_arbiter #(
    .BURST_MAX   (BURST_MAX),
    .FAIR_GAP    (FAIR_GAP),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .cpu_rdy   (cpu_rdy),
    .cpu_be    (cpu_be),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rw    (dma_rw),
    .dma_gnt   (dma_gnt),
    .dma_done  (dma_done),
    .dma_rdata (dma_rdata),
    .bus_oe    (bus_oe),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rw    (bus_rw),
    .bus_rdata (bus_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model behind the bus.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'hEA;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign bus_rdata = (bus_oe && bus_rw) ? mem_rd(bus_addr) : 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] code();
    return {cpu_rdy, cpu_be, bus_oe, dma_gnt, dma_done};
  endfunction

  task automatic present();
    acc_t a;
    a = pend.pop_front();
    dma_addr  = a.addr;
    dma_wdata = a.wdata;
    dma_rw    = a.rw;
    dma_req   = 1'b1;
    sb.push_back(a);
  endtask

  // Monitor, scoreboard and master driver.
  always @(negedge clock) begin
    acc_t a;
    logic [7:0] exp_rd;
    if (reset_b) begin
      check_val("be_vs_rdy", {31'd0, cpu_be | ~cpu_rdy}, 32'd1);
      check_val("oe_vs_be", {31'd0, ~(bus_oe & cpu_be)}, 32'd1);
      if (dma_gnt && !dma_done) begin
        if (sb.size() == 0) begin
          check_val("xfer_unexpected", 32'd0, 32'd1);
        end else begin
          a = sb[0];
          check_val("xfer_addr", {16'd0, bus_addr}, {16'd0, a.addr});
          check_val("xfer_rw", {31'd0, bus_rw}, {31'd0, a.rw});
          check_val("xfer_wdata", {24'd0, bus_wdata}, {24'd0, a.wdata});
        end
      end
      if (dma_done) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check_val("done_unexpected", 32'd0, 32'd1);
        end else begin
          a = sb.pop_front();
          exp_rd = a.rw ? mem_rd(a.addr) : last_rdata;
          check_val("done_rdata", {24'd0, dma_rdata}, {24'd0, exp_rd});
          last_rdata = exp_rd;
        end
        if (drv_en) begin
          if (pend.size() > 0) present();
          else dma_req = 1'b0;
        end
      end
    end
  end

  task automatic settle();
    repeat (FAIR_GAP + 6) @(negedge clock);
  endtask

  // One access: checks the cycle-by-cycle state sequence from the request.
  task automatic run_timed(input string name);
    logic [4:0] exp;
    present();
    for (int k = 1; k <= XW + 5; k++) begin
      @(negedge clock);
      if (k == 1) exp = C_HALT;
      else if (k == 2) exp = C_FLOAT;
      else if (k <= 2 + XW) exp = C_XFER;
      else if (k == 3 + XW) exp = C_ACK;
      else if (k == 4 + XW) exp = C_RETURN;
      else exp = C_IDLE;
      check_val($sformatf("%s_c%0d", name, k), {27'd0, code()}, {27'd0, exp});
    end
  endtask

  task automatic wait_dones(input int n, input int budget);
    int t;
    t = 0;
    while (done_cyc.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_val("done_count", done_cyc.size(), n);
  endtask

  initial begin
    int n16, idle_n, phase, t;
    bit oe_seen;
    reset_b   = 1'b0;
    dma_req   = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    dma_rw    = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst_code", {27'd0, code()}, {27'd0, C_IDLE});
    check_val("rst_rw", {31'd0, bus_rw}, 32'd1);
    check_val("rst_addr", {16'd0, bus_addr}, 32'd0);
    check_val("rst_rdata", {24'd0, dma_rdata}, 32'd0);
    reset_b = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check_val("idle_code", {27'd0, code()}, {27'd0, C_IDLE});
      check_val("idle_rw", {31'd0, bus_rw}, 32'd1);
    end

    // Single read of the reset vector.
    drv_en = 1'b1;
    pend.push_back('{16'hFFFC, 8'h00, 1'b1});
    run_timed("rd");
    repeat (3) @(negedge clock);
    check_val("rdata_hold", {24'd0, dma_rdata}, 32'hEA);

    // Three-access write burst.
    settle();
    pend.push_back('{16'h0200, 8'h11, 1'b0});
    pend.push_back('{16'h0201, 8'h22, 1'b0});
    pend.push_back('{16'h0202, 8'h33, 1'b0});
    done_cyc.delete();
    present();
    wait_dones(3, 60);
    if (done_cyc.size() >= 3) begin
      check_val("burst_gap1", done_cyc[1] - done_cyc[0], XW + 1);
      check_val("burst_gap2", done_cyc[2] - done_cyc[1], XW + 1);
    end
    check_val("wr_rdata_kept", {24'd0, dma_rdata}, 32'hEA);

    // Continuous request: burst cap, release and fairness gap.
    settle();
    for (int i = 0; i < 20; i++)
      pend.push_back('{16'h8000 + 16'(i), 8'(i * 7), 1'(i % 2)});
    done_cyc.delete();
    present();
    n16 = 0; idle_n = 0; phase = 0; t = 0;
    while (phase < 2 && t < 400) begin
      @(negedge clock);
      t++;
      if (phase == 0) begin
        if (dma_done) n16++;
        if (code() == C_RETURN && n16 > 0) phase = 1;
      end else begin
        if (code() == C_IDLE) idle_n++;
        else if (code() == C_HALT) phase = 2;
      end
    end
    check_val("cap_reached_halt", phase, 2);
    check_val("cap_dones", n16, BURST_MAX);
    check_val("fair_idle", idle_n, FAIR_GAP);
    wait_dones(20, 200);

    // Request withdrawn during FLOAT.
    settle();
    drv_en = 1'b0;
    dma_addr = 16'h4000; dma_rw = 1'b1; dma_req = 1'b1;
    done_cyc.delete();
    oe_seen = 1'b0;
    t = 0;
    do begin
      @(negedge clock);
      t++;
      oe_seen |= bus_oe;
    end while (code() != C_FLOAT && t < 10);
    check_val("float_reached", {27'd0, code()}, {27'd0, C_FLOAT});
    dma_req = 1'b0;
    @(negedge clock);
    check_val("float_return", {27'd0, code()}, {27'd0, C_RETURN});
    repeat (10) begin
      @(negedge clock);
      oe_seen |= bus_oe;
    end
    check_val("float_no_oe", {31'd0, oe_seen}, 32'd0);
    check_val("float_no_done", done_cyc.size(), 0);

    // Reset asserted in the middle of a write XFER.
    settle();
    drv_en = 1'b1;
    pend.push_back('{16'h0300, 8'h77, 1'b0});
    present();
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (code() != C_XFER && t < 10);
    check_val("xfer_reached", {27'd0, code()}, {27'd0, C_XFER});
    #2 reset_b = 1'b0;
    #1;
    check_val("arst_code", {27'd0, code()}, {27'd0, C_IDLE});
    check_val("arst_addr", {16'd0, bus_addr}, 32'd0);
    check_val("arst_wdata", {24'd0, bus_wdata}, 32'd0);
    check_val("arst_rw", {31'd0, bus_rw}, 32'd1);
    check_val("arst_rdata", {24'd0, dma_rdata}, 32'd0);
    sb.delete();
    pend.delete();
    dma_req = 1'b0;
    last_rdata = 8'h00;
    repeat (2) @(negedge clock);
    reset_b = 1'b1;
    @(negedge clock);
    pend.push_back('{16'h1234, 8'h00, 1'b1});
    run_timed("post_rst");

    repeat (5) @(negedge clock);
    check_val("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
